encoder_frame_ctrl: RTL and testbench

- Per-frame sequencer in front of the convolutional encoder.
- Accepts a frame descriptor (rate, PSDU length) and builds the 24-bit SIGNAL word, presented with tuser = `RATE_6M`.
- Then passes scrambled 24-bit data words from upstream to the encoder, tagged with the frame rate, and asserts tlast on the final padded word.
- Sits between the scrambler output stream and the encoder s_axis port.

---
 rtl/encoder_frame_ctrl_if.sv | 38 +++
 rtl/encoder_frame_ctrl.sv | 129 ++++++++++++
 tb/tb_encoder_frame_ctrl.sv | 270 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/encoder_frame_ctrl_if.sv
// Stream bundle for encoder_frame_ctrl: frame descriptor input, scrambled data
// input, and the output stream toward the convolutional encoder.
interface encoder_frame_ctrl_if #(
  parameter int WIDTH = 24,
  parameter int LEN_W = 12
);
  logic [LEN_W+3:0] cfg_tdata;
  logic             cfg_tvalid;
  logic             cfg_tready;

  logic [WIDTH-1:0] s_axis_tdata;
  logic             s_axis_tvalid;
  logic             s_axis_tready;

  logic [WIDTH-1:0] m_axis_tdata;
  logic [3:0]       m_axis_tuser;
  logic             m_axis_tvalid;
  logic             m_axis_tready;
  logic             m_axis_tlast;

  modport master (
    output cfg_tdata, cfg_tvalid,
    input  cfg_tready,
    output s_axis_tdata, s_axis_tvalid,
    input  s_axis_tready,
    input  m_axis_tdata, m_axis_tuser, m_axis_tvalid, m_axis_tlast,
    output m_axis_tready
  );

  modport slave (
    input  cfg_tdata, cfg_tvalid,
    output cfg_tready,
    input  s_axis_tdata, s_axis_tvalid,
    output s_axis_tready,
    output m_axis_tdata, m_axis_tuser, m_axis_tvalid, m_axis_tlast,
    input  m_axis_tready
  );
endinterface

// File: rtl/encoder_frame_ctrl.sv
// Per-frame sequencer ahead of the convolutional encoder: emits the SIGNAL word,
// then forwards scrambled data words tagged with the frame rate until the padded end.
module encoder_frame_ctrl #(
  parameter int WIDTH = 24,
  parameter int LEN_W = 12
) (
  input  logic                 aclk,
  input  logic                 areset,
  encoder_frame_ctrl_if.slave  bus,
  output logic                 busy,
  output logic                 frame_done,
  output logic                 cfg_err
);

  localparam logic [3:0] RATE_6M  = 4'b1011;
  localparam logic [3:0] RATE_9M  = 4'b1111;
  localparam logic [3:0] RATE_12M = 4'b1010;
  localparam logic [3:0] RATE_18M = 4'b1110;
  localparam logic [3:0] RATE_24M = 4'b1001;
  localparam logic [3:0] RATE_36M = 4'b1101;
  localparam logic [3:0] RATE_48M = 4'b1000;
  localparam logic [3:0] RATE_54M = 4'b1100;

  typedef enum logic [1:0] {IDLE, CALC, SIGNAL, DATA} state_t;

  state_t           state;
  logic [3:0]       rate_q;
  logic [LEN_W-1:0] len_q;
  logic [15:0]      acc;
  logic [15:0]      remaining;
  logic [WIDTH-1:0] sig_q;

  logic [3:0]       cfg_rate;
  logic [LEN_W-1:0] cfg_len;
  logic [15:0]      need;
  logic [15:0]      acc_next;
  logic [WIDTH-1:0] sig_word;

  // Zero marks an unsupported rate code.
  function automatic logic [7:0] dbps_of(input logic [3:0] r);
    case (r)
      RATE_6M:  return 8'd24;
      RATE_9M:  return 8'd36;
      RATE_12M: return 8'd48;
      RATE_18M: return 8'd72;
      RATE_24M: return 8'd96;
      RATE_36M: return 8'd144;
      RATE_48M: return 8'd192;
      RATE_54M: return 8'd216;
      default:  return 8'd0;
    endcase
  endfunction

  assign cfg_rate = bus.cfg_tdata[LEN_W+3:LEN_W];
  assign cfg_len  = bus.cfg_tdata[LEN_W-1:0];
  assign need     = 16'd22 + 16'({len_q, 3'b000});
  assign acc_next = acc + 16'(dbps_of(rate_q));
  assign sig_word = WIDTH'({6'b0, ^{len_q, 1'b0, rate_q}, len_q, 1'b0, rate_q});

  // DATA is a combinational pass-through; other states present registered values.
  always_comb begin
    bus.cfg_tready    = (state == IDLE);
    busy              = (state != IDLE);
    bus.m_axis_tdata  = sig_q;
    bus.m_axis_tuser  = RATE_6M;
    bus.m_axis_tvalid = (state == SIGNAL);
    bus.m_axis_tlast  = 1'b0;
    bus.s_axis_tready = 1'b0;
    if (state == DATA) begin
      bus.m_axis_tdata  = bus.s_axis_tdata;
      bus.m_axis_tuser  = rate_q;
      bus.m_axis_tvalid = bus.s_axis_tvalid;
      bus.m_axis_tlast  = (remaining <= 16'(WIDTH));
      bus.s_axis_tready = bus.m_axis_tready;
    end
  end

  always_ff @(posedge aclk) begin
    if (areset) begin
      state      <= IDLE;
      rate_q     <= '0;
      len_q      <= '0;
      acc        <= '0;
      remaining  <= '0;
      sig_q      <= '0;
      frame_done <= 1'b0;
      cfg_err    <= 1'b0;
    end else begin
      frame_done <= 1'b0;
      cfg_err    <= 1'b0;
      unique case (state)
        IDLE: begin
          if (bus.cfg_tvalid) begin
            rate_q <= cfg_rate;
            len_q  <= cfg_len;
            acc    <= '0;
            if (dbps_of(cfg_rate) == 8'd0 || cfg_len == '0) cfg_err <= 1'b1;
            else                                            state   <= CALC;
          end
        end
        // Repeated addition stands in for ceil(need/N_DBPS)*N_DBPS, one symbol per cycle.
        CALC: begin
          acc <= acc_next;
          if (acc_next >= need) begin
            remaining <= acc_next;
            sig_q     <= sig_word;
            state     <= SIGNAL;
          end
        end
        SIGNAL: begin
          if (bus.m_axis_tready) begin
            sig_q <= '0;
            state <= DATA;
          end
        end
        DATA: begin
          if (bus.s_axis_tvalid && bus.m_axis_tready) begin
            remaining <= remaining - 16'(WIDTH);
            if (remaining <= 16'(WIDTH)) begin
              frame_done <= 1'b1;
              state      <= IDLE;
            end
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_encoder_frame_ctrl.sv
// Bench for encoder_frame_ctrl: directed descriptor table, held-off descriptor,
// mid-frame reset, and randomized frames under backpressure against a rate/length model.
module tb_encoder_frame_ctrl;

  localparam logic [3:0] RATE_6M  = 4'b1011;
  localparam logic [3:0] RATE_9M  = 4'b1111;
  localparam logic [3:0] RATE_12M = 4'b1010;
  localparam logic [3:0] RATE_18M = 4'b1110;
  localparam logic [3:0] RATE_24M = 4'b1001;
  localparam logic [3:0] RATE_36M = 4'b1101;
  localparam logic [3:0] RATE_48M = 4'b1000;
  localparam logic [3:0] RATE_54M = 4'b1100;

  logic aclk;
  logic areset;
  logic busy, frame_done, cfg_err;

  encoder_frame_ctrl_if #(.WIDTH(24), .LEN_W(12)) bus ();

  encoder_frame_ctrl #(.WIDTH(24), .LEN_W(12)) dut (
    .aclk       (aclk),
    .areset     (areset),
    .bus        (bus),
    .busy       (busy),
    .frame_done (frame_done),
    .cfg_err    (cfg_err)
  );

  initial aclk = 1'b0;
  always #5 aclk = ~aclk;

  int n_total = 0;
  int n_pass  = 0;

  typedef struct {
    logic [3:0]  rate;
    logic [11:0] len;
    bit          bp;
    bit          exp_err;
    int          exp_nsym;
    int          exp_words;
  } vec_t;

  vec_t tab[12];
  logic [3:0] codes[8];

  task automatic chk(input string name, input int act, input int exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
  endtask

  // Model from the rate table: data bits per OFDM symbol.
  function automatic int dbps(input logic [3:0] r);
    case (r)
      RATE_6M:  return 24;
      RATE_9M:  return 36;
      RATE_12M: return 48;
      RATE_18M: return 72;
      RATE_24M: return 96;
      RATE_36M: return 144;
      RATE_48M: return 192;
      RATE_54M: return 216;
      default:  return 0;
    endcase
  endfunction

  function automatic int model_nsym(input logic [3:0] r, input logic [11:0] l);
    int need = 22 + 8 * int'(l);
    return (need + dbps(r) - 1) / dbps(r);
  endfunction

  function automatic int model_words(input logic [3:0] r, input logic [11:0] l);
    return (model_nsym(r, l) * dbps(r) + 23) / 24;
  endfunction

  function automatic logic [23:0] model_sig(input logic [3:0] r, input logic [11:0] l);
    logic [23:0] w = '0;
    for (int i = 0; i < 4; i++)  w[i] = r[i];
    for (int i = 0; i < 12; i++) w[5 + i] = l[i];
    w[17] = ($countones(w) % 2) == 1;
    return w;
  endfunction

  task automatic recover();
    areset = 1'b1;
    bus.cfg_tvalid = 1'b0; bus.s_axis_tvalid = 1'b0; bus.m_axis_tready = 1'b0;
    @(posedge aclk); #1;
    areset = 1'b0;
    @(negedge aclk);
  endtask

  // Starts and ends just after a negedge. hold_next leaves next_desc presented after acceptance.
  task automatic run_frame(input logic [3:0] rate, input logic [11:0] len, input bit bp,
                           input int exp_nsym, input int exp_words,
                           input bit hold_next, input logic [15:0] next_desc, input int abort_at);
    int cyc, wc;
    bit bad_ctl, hold_bad, pass_bad, word_bad, tlast_bad, aborted, pend_v;
    logic [23:0] sw, pend;
    bus.cfg_tdata = {rate, len};
    bus.cfg_tvalid = 1'b1;
    bus.m_axis_tready = 1'b0;
    bus.s_axis_tvalid = 1'b0;
    cyc = 0;
    while (!bus.cfg_tready && cyc < 3000) begin
      @(posedge aclk); #1; @(negedge aclk); cyc++;
    end
    if (!bus.cfg_tready) begin
      chk("cfg_accept_timeout", 0, 1); recover(); return;
    end
    @(posedge aclk); #1;
    if (hold_next) bus.cfg_tdata = next_desc;
    else           bus.cfg_tvalid = 1'b0;

    cyc = 0; bad_ctl = 0;
    @(negedge aclk);
    while (!bus.m_axis_tvalid && cyc < 2000) begin
      cyc++;
      if (bus.cfg_tready || !busy || frame_done || cfg_err) bad_ctl = 1;
      @(posedge aclk); #1; @(negedge aclk);
    end
    chk("calc_cycles", cyc, exp_nsym);
    if (!bus.m_axis_tvalid) begin recover(); return; end

    sw = model_sig(rate, len);
    chk("sig_tdata", int'(bus.m_axis_tdata), int'(sw));
    chk("sig_tuser", int'(bus.m_axis_tuser), int'(RATE_6M));
    chk("sig_tlast", int'(bus.m_axis_tlast), 0);
    chk("sig_s_tready", int'(bus.s_axis_tready), 0);
    cyc = 0; hold_bad = 0;
    do begin
      @(posedge aclk); #1;
      bus.m_axis_tready = bp ? 1'($urandom_range(0, 1)) : 1'b1;
      @(negedge aclk); cyc++;
      if (!bus.m_axis_tvalid || bus.m_axis_tdata !== sw || bus.m_axis_tuser !== RATE_6M ||
          bus.m_axis_tlast !== 1'b0 || bus.s_axis_tready !== 1'b0 || !busy || bus.cfg_tready)
        hold_bad = 1;
    end while (!bus.m_axis_tready && cyc < 100);
    chk("sig_hold", int'(hold_bad), 0);

    wc = 0; cyc = 0; pend_v = 0; pend = '0;
    pass_bad = 0; word_bad = 0; tlast_bad = 0; aborted = 0;
    while (wc < exp_words && cyc < 20000) begin
      @(posedge aclk); #1;
      if (!pend_v) begin pend = 24'($urandom); pend_v = 1; end
      bus.s_axis_tdata  = pend;
      bus.s_axis_tvalid = bp ? ($urandom_range(0, 3) != 0) : 1'b1;
      bus.m_axis_tready = bp ? ($urandom_range(0, 3) != 0) : 1'b1;
      @(negedge aclk); cyc++;
      if (bus.m_axis_tvalid !== bus.s_axis_tvalid || bus.s_axis_tready !== bus.m_axis_tready) pass_bad = 1;
      if (bus.cfg_tready || frame_done || !busy) bad_ctl = 1;
      if (bus.s_axis_tvalid && bus.m_axis_tready) begin
        wc++;
        if (bus.m_axis_tdata !== pend || bus.m_axis_tuser !== rate) word_bad = 1;
        if (bus.m_axis_tlast !== (wc == exp_words)) tlast_bad = 1;
        pend_v = 0;
        if (abort_at != 0 && wc == abort_at) begin areset = 1'b1; aborted = 1; break; end
      end
    end
    chk("data_passthrough", int'(pass_bad), 0);
    chk("data_word", int'(word_bad), 0);
    chk("data_tlast", int'(tlast_bad), 0);
    chk("held_off_ctl", int'(bad_ctl), 0);

    if (aborted) begin
      @(posedge aclk); #1;
      areset = 1'b0;
      @(negedge aclk);
      chk("abort_tvalid", int'(bus.m_axis_tvalid), 0);
      chk("abort_busy", int'(busy), 0);
      chk("abort_done", int'(frame_done), 0);
      chk("abort_tlast", int'(bus.m_axis_tlast), 0);
      bus.s_axis_tvalid = 1'b0; bus.m_axis_tready = 1'b0;
      @(posedge aclk); #1; @(negedge aclk);
      chk("abort_done_late", int'(frame_done), 0);
      return;
    end

    chk("word_count", wc, exp_words);
    if (wc != exp_words) begin recover(); return; end
    @(posedge aclk); #1;
    bus.s_axis_tvalid = 1'b0; bus.m_axis_tready = 1'b0;
    @(negedge aclk);
    chk("frame_done", int'(frame_done), 1);
    chk("end_busy", int'(busy), 0);
    chk("end_cfg_tready", int'(bus.cfg_tready), 1);
  endtask

  task automatic run_bad(input logic [3:0] rate, input logic [11:0] len);
    bus.cfg_tdata = {rate, len};
    bus.cfg_tvalid = 1'b1;
    chk("bad_cfg_tready", int'(bus.cfg_tready), 1);
    @(posedge aclk); #1;
    bus.cfg_tvalid = 1'b0;
    @(negedge aclk);
    chk("bad_cfg_err", int'(cfg_err), 1);
    chk("bad_busy", int'(busy), 0);
    chk("bad_tvalid", int'(bus.m_axis_tvalid), 0);
    @(posedge aclk); #1; @(negedge aclk);
    chk("bad_cfg_err_pulse", int'(cfg_err), 0);
    chk("bad_busy_after", int'(busy), 0);
    chk("bad_tvalid_after", int'(bus.m_axis_tvalid), 0);
  endtask

  initial begin
    #5000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    tab[0]  = '{RATE_6M,  12'd100,  1'b0, 1'b0, 35,  35};
    tab[1]  = '{RATE_9M,  12'd100,  1'b1, 1'b0, 23,  35};
    tab[2]  = '{RATE_54M, 12'd100,  1'b0, 1'b0, 4,   36};
    tab[3]  = '{RATE_6M,  12'd1,    1'b0, 1'b0, 2,   2};
    tab[4]  = '{RATE_36M, 12'd1,    1'b1, 1'b0, 1,   6};
    tab[5]  = '{4'b0000,  12'd100,  1'b0, 1'b1, 0,   0};
    tab[6]  = '{RATE_6M,  12'd0,    1'b0, 1'b1, 0,   0};
    tab[7]  = '{4'b0111,  12'd50,   1'b0, 1'b1, 0,   0};
    tab[8]  = '{RATE_12M, 12'd4095, 1'b0, 1'b0, 683, 1366};
    tab[9]  = '{RATE_48M, 12'd20,   1'b1, 1'b0, 1,   8};
    tab[10] = '{RATE_18M, 12'd7,    1'b1, 1'b0, 2,   6};
    tab[11] = '{RATE_24M, 12'd3,    1'b0, 1'b0, 1,   4};
    codes = '{RATE_6M, RATE_9M, RATE_12M, RATE_18M, RATE_24M, RATE_36M, RATE_48M, RATE_54M};

    areset = 1'b1;
    bus.cfg_tdata = '0; bus.cfg_tvalid = 1'b0;
    bus.s_axis_tdata = '0; bus.s_axis_tvalid = 1'b0;
    bus.m_axis_tready = 1'b0;
    repeat (2) @(posedge aclk);
    @(negedge aclk);
    chk("rst_cfg_tready", int'(bus.cfg_tready), 1);
    chk("rst_tvalid", int'(bus.m_axis_tvalid), 0);
    chk("rst_tlast", int'(bus.m_axis_tlast), 0);
    chk("rst_s_tready", int'(bus.s_axis_tready), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_frame_done", int'(frame_done), 0);
    chk("rst_cfg_err", int'(cfg_err), 0);
    chk("rst_tdata", int'(bus.m_axis_tdata), 0);
    chk("rst_tuser", int'(bus.m_axis_tuser), int'(RATE_6M));
    @(posedge aclk); #1;
    areset = 1'b0;
    @(negedge aclk);

    for (int i = 0; i < 12; i++) begin
      if (tab[i].exp_err) run_bad(tab[i].rate, tab[i].len);
      else run_frame(tab[i].rate, tab[i].len, tab[i].bp, tab[i].exp_nsym, tab[i].exp_words, 1'b0, '0, 0);
    end

    // Second descriptor presented throughout the first frame, taken right after it.
    run_frame(RATE_6M, 12'd1, 1'b1, 2, 2, 1'b1, {RATE_12M, 12'd5}, 0);
    run_frame(RATE_12M, 12'd5, 1'b0, 2, 4, 1'b0, '0, 0);

    // Reset on data word 10, then a short frame must still complete.
    run_frame(RATE_6M, 12'd100, 1'b0, 35, 35, 1'b0, '0, 10);
    run_frame(RATE_6M, 12'd1, 1'b0, 2, 2, 1'b0, '0, 0);

    for (int i = 0; i < 10; i++) begin
      logic [3:0]  r;
      logic [11:0] l;
      r = codes[$urandom_range(0, 7)];
      l = 12'($urandom_range(1, 200));
      run_frame(r, l, 1'b1, model_nsym(r, l), model_words(r, l), 1'b0, '0, 0);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
